// File: rtl/axi_to_mem_wr.sv
// ============================================================================
// Module      : axi_to_mem_wr
// Description : AXI4 write-path stage for axi_to_mem. Accepts atop-free
//               write bursts on flattened AW/W/B channels, issues one memory
//               write request per W beat with per-beat address generation,
//               and returns one B response per burst.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   aw_*                       AXI write address channel (id/addr/len/size/burst)
//   w_*                        AXI write data channel (data/strb/last)
//   b_*                        AXI write response channel (id/resp)
//   mem_req_o / mem_gnt_i      memory write request / grant handshake
//   mem_addr_o/wdata_o/strb_o  memory byte address, data, byte enables
// Configuration
//   AXI_TO_MEM_WR_WRAP_EN      when defined, WRAP bursts with len in
//                              {1,3,7,15} are supported; otherwise every
//                              WRAP burst is sunk and answered with SLVERR.
// ============================================================================
`default_nettype none

module axi_to_mem_wr #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // AW channel
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic [2:0]           aw_size_i,
    input  logic [1:0]           aw_burst_i,
    // W channel
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 w_last_i,
    // B channel
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    // Memory write port
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [StrbWidth-1:0] mem_strb_o
);

    localparam logic [2:0]           SizeMax = 3'($clog2(StrbWidth));
    localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
    localparam logic [1:0]           RespOkay   = 2'b00;
    localparam logic [1:0]           RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_SINK  = 3'd3,
        ST_BRESP = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;

    logic                 aw_illegal;
    logic                 beat_done;
    logic                 last_beat;
    logic [AddrWidth-1:0] unit;
    logic [AddrWidth-1:0] aligned;
    logic [AddrWidth-1:0] next_addr;

    // ------------------------------------------------------------------
    // Legality of an incoming AW: beat wider than the bus or reserved burst
    // ------------------------------------------------------------------
    always_comb begin
        aw_illegal = (aw_size_i > SizeMax) || (aw_burst_i == 2'b11);
`ifdef AXI_TO_MEM_WR_WRAP_EN
        if ((aw_burst_i == 2'b10) &&
            !((aw_len_i == 8'd1) || (aw_len_i == 8'd3) ||
              (aw_len_i == 8'd7) || (aw_len_i == 8'd15))) begin
            aw_illegal = 1'b1;
        end
`else
        if (aw_burst_i == 2'b10) begin
            aw_illegal = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Per-beat address generation. Only legal bursts reach WRITE, so the
    // shift below never exceeds the bus width.
    // ------------------------------------------------------------------
    assign unit    = AddrOne << size_q;
    assign aligned = addr_q & ~(unit - AddrOne);

`ifdef AXI_TO_MEM_WR_WRAP_EN
    logic [AddrWidth-1:0] span;
    logic [AddrWidth-1:0] wrap_base;

    // Legal WRAP lengths are 2/4/8/16 beats, so span is a power-of-two
    // multiple of unit and can be formed with a shift.
    always_comb begin
        case (len_q[3:0])
            4'd1:    span = unit << 1;
            4'd3:    span = unit << 2;
            4'd7:    span = unit << 3;
            default: span = unit << 4;
        endcase
    end

    assign wrap_base = addr_q & ~(span - AddrOne);
`endif

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = aligned + unit;
`ifdef AXI_TO_MEM_WR_WRAP_EN
            2'b10:   next_addr = wrap_base | ((aligned + unit) & (span - AddrOne));
`endif
            default: next_addr = addr_q;
        endcase
    end

    assign last_beat = (beat_cnt_q == len_q);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        beat_done  = 1'b0;

        aw_ready_o  = 1'b0;
        w_ready_o   = 1'b0;
        b_valid_o   = 1'b0;
        b_id_o      = '0;
        b_resp_o    = RespOkay;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end

            ST_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    id_d       = aw_id_i;
                    addr_d     = aw_addr_i;
                    len_d      = aw_len_i;
                    size_d     = aw_size_i;
                    burst_d    = aw_burst_i;
                    beat_cnt_d = 8'd0;
                    err_d      = aw_illegal;
                    state_d    = aw_illegal ? ST_SINK : ST_WRITE;
                end
            end

            // Zero-latency pass-through: the W handshake is the memory grant.
            ST_WRITE: begin
                mem_req_o   = w_valid_i;
                w_ready_o   = mem_gnt_i;
                mem_addr_o  = addr_q;
                mem_wdata_o = w_data_i;
                mem_strb_o  = w_strb_i;
                beat_done   = w_valid_i && mem_gnt_i;
            end

            // Illegal burst: drain its beats without touching memory.
            ST_SINK: begin
                w_ready_o = 1'b1;
                beat_done = w_valid_i;
            end

            ST_BRESP: begin
                b_valid_o = 1'b1;
                b_id_o    = id_q;
                b_resp_o  = err_q ? RespSlvErr : RespOkay;
                if (b_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Termination is purely count-based; a disagreeing w_last only
        // poisons the response.
        if (beat_done) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = next_addr;
            if (w_last_i != last_beat) begin
                err_d = 1'b1;
            end
            if (last_beat) begin
                state_d = ST_BRESP;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and burst context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RESET;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_to_mem_wr.sv
// ============================================================================
// Module      : tb_axi_to_mem_wr
// Description : Self-checking bench for axi_to_mem_wr. Directed bursts from
//               the plan followed by randomized bursts, all checked against a
//               burst-level reference model of addresses and responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_to_mem_wr;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          aw_valid;
    logic          aw_ready;
    logic [IW-1:0] aw_id;
    logic [AW-1:0] aw_addr;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size;
    logic [1:0]    aw_burst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          w_last;
    logic          b_valid;
    logic          b_ready;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_strb;

    int nvec;
    int nfail;

    axi_to_mem_wr #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .aw_id_i     (aw_id),
        .aw_addr_i   (aw_addr),
        .aw_len_i    (aw_len),
        .aw_size_i   (aw_size),
        .aw_burst_i  (aw_burst),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_data_i    (w_data),
        .w_strb_i    (w_strb),
        .w_last_i    (w_last),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_strb_o  (mem_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst legality from the AXI rules for this slave.
    function automatic bit model_err(input int len, input int size, input int burst);
        if (size > 3) return 1'b1;
        if (burst == 3) return 1'b1;
`ifdef AXI_TO_MEM_WR_WRAP_EN
        if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15);
`else
        if (burst == 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Address of beat i computed directly from the burst description.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input int size, input int burst, input int i);
        logic [31:0] unit, aligned, span, base;
        unit    = 32'd1 << size;
        aligned = a & ~(unit - 32'd1);
        if (i == 0 || burst == 0) return a;
        if (burst == 1) return aligned + 32'(i) * unit;
        span = 32'(len + 1) * unit;
        base = a & ~(span - 32'd1);
        return base + ((aligned - base + 32'(i) * unit) % span);
    endfunction

    // mode 0: random valid/grant, 1: always valid+granted, 2: grant toggles.
    // bad: beat index with a flipped w_last (-1 for none).
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input int burst, input int bad,
                             input int mode, input int bhold);
        bit          sink, err, hs, v, g;
        int          beat, cyc;
        logic [63:0] d;
        logic [7:0]  s;
        sink = model_err(len, size, burst);
        err  = sink || (bad >= 0 && bad <= len);

        // AW phase with an early W beat that must be stalled
        aw_valid = 1'b1; aw_id = id; aw_addr = addr;
        aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
        w_valid = 1'b1; w_last = 1'b0;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            #1;
            chk("w_ready_idle", w_ready, 0);
            chk("mem_req_idle", mem_req, 0);
            hs = aw_ready;
            @(negedge clk);
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("aw_handshake", hs, 1);

        // W phase
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 400) begin
            case (mode)
                1:       begin v = 1'b1; g = 1'b1; end
                2:       begin v = 1'b1; g = (cyc % 2) == 1; end
                default: begin v = ($urandom_range(0, 3) != 0); g = ($urandom_range(0, 2) != 0); end
            endcase
            d = {$urandom, $urandom};
            s = 8'($urandom);
            w_valid = v; w_data = d; w_strb = s; mem_gnt = g;
            w_last = (beat == len) != (beat == bad);
            #1;
            chk("aw_ready_busy", aw_ready, 0);
            chk("b_valid_busy", b_valid, 0);
            if (sink) begin
                chk("mem_req_sink", mem_req, 0);
                chk("w_ready_sink", w_ready, 1);
            end else begin
                chk("mem_req", mem_req, v);
                chk("w_ready", w_ready, g);
                if (v) begin
                    chk("mem_addr", mem_addr, model_addr(addr, len, size, burst, beat));
                    chk("mem_wdata", mem_wdata, d);
                    chk("mem_strb", mem_strb, s);
                end
            end
            if (v && (sink || g)) beat++;
            @(negedge clk);
            cyc++;
        end
        w_valid = 1'b0; mem_gnt = 1'b0; w_last = 1'b0;
        chk("beats_done", beat > len, 1);

        // B phase with optional backpressure
        b_ready = 1'b0;
        for (int k = 0; k < bhold; k++) begin
            #1;
            chk("b_valid_hold", b_valid, 1);
            chk("b_id_hold", b_id, id);
            chk("b_resp_hold", b_resp, err ? 2'b10 : 2'b00);
            chk("aw_ready_bresp", aw_ready, 0);
            @(negedge clk);
        end
        b_ready = 1'b1;
        #1;
        chk("b_valid", b_valid, 1);
        chk("b_id", b_id, id);
        chk("b_resp", b_resp, err ? 2'b10 : 2'b00);
        @(negedge clk);
        b_ready = 1'b0;
        #1;
        chk("b_valid_after", b_valid, 0);
        chk("aw_ready_after", aw_ready, 1);
    endtask

    initial begin
        int lens[5];
        int len, size, burst, bad;
        bit hs;
        nvec = 0; nfail = 0;
        lens = '{0, 1, 3, 7, 15};
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; mem_gnt = 0;

        // Reset state
        rst_n = 1'b0;
        #1;
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_b_id", b_id, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_aw_ready0", aw_ready, 0);
        @(negedge clk);
        #1;
        chk("post_rst_aw_ready1", aw_ready, 1);

        // Directed bursts
        run_burst(4'h5, 32'h1000, 3, 3, 1, -1, 1, 0);   // INCR aligned
        run_burst(4'h6, 32'h1003, 1, 3, 1, -1, 1, 5);   // unaligned INCR, B backpressure
        run_burst(4'h7, 32'h0040, 2, 3, 0, -1, 2, 1);   // FIXED, toggling grant
        run_burst(4'h8, 32'h0100, 1, 4, 1, -1, 0, 0);   // oversize beat
        run_burst(4'h9, 32'h0200, 1, 3, 1, 0, 1, 0);    // early w_last
        run_burst(4'hA, 32'h0038, 3, 3, 2, -1, 1, 0);   // WRAP
        run_burst(4'hB, 32'h0000, 2, 2, 3, -1, 0, 2);   // reserved burst type

        // Reset mid-burst
        aw_valid = 1'b1; aw_id = 4'h3; aw_addr = 32'h2000;
        aw_len = 8'd7; aw_size = 3'd3; aw_burst = 2'b01;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            #1; hs = aw_ready; @(negedge clk);
        end
        aw_valid = 1'b0;
        chk("mid_rst_aw_handshake", hs, 1);
        w_valid = 1'b1; mem_gnt = 1'b1; w_data = 64'hDEAD_BEEF_0000_0001; w_strb = 8'hFF;
        @(negedge clk); @(negedge clk);
        #1;
        chk("mid_rst_req_before", mem_req, 1);
        chk("mid_rst_addr_before", mem_addr, 32'h2010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_w_ready", w_ready, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_aw_ready", aw_ready, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        @(negedge clk); @(negedge clk);
        w_valid = 1'b0; mem_gnt = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_aw0", aw_ready, 0);
        chk("mid_rst_release_b", b_valid, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_release_aw1", aw_ready, 1);
        chk("mid_rst_no_b", b_valid, 0);

        // Randomized bursts
        for (int n = 0; n < 40; n++) begin
            len   = lens[$urandom_range(0, 4)];
            size  = $urandom_range(0, 4);
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            bad   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            run_burst(4'($urandom), $urandom, len, size, burst, bad, 0, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_to_mem_wr.md
Name: axi_to_mem_wr

Overview:
- Write-path stage directly downstream of the AXI atomic-operation filter in axi_to_mem.
- Accepts atop-free AXI4 write bursts on flattened AW/W/B channels and issues one memory write request per W beat, with per-beat address generation.
- Returns one B response per burst.
- Read path and atomics are out of scope; atops are already stripped upstream.

Parameters:
- AddrWidth, 32, AW and memory address width.
- DataWidth, 64, W data and memory data width; power of two, >= 8.
- IdWidth, 4, AXI ID width.
- StrbWidth, DataWidth/8, derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- aw_id_i  in  IdWidth  AW ID
- aw_addr_i  in  AddrWidth  start address
- aw_len_i  in  8  beats minus one
- aw_size_i  in  3  log2 bytes per beat
- aw_burst_i  in  2  FIXED=00, INCR=01, WRAP=10
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- w_data_i  in  DataWidth  write data
- w_strb_i  in  StrbWidth  byte strobes
- w_last_i  in  1  last beat flag
- b_valid_o  out  1  B valid
- b_ready_i  in  1  B ready
- b_id_o  out  IdWidth  B ID
- b_resp_o  out  2  OKAY=00, SLVERR=10
- mem_req_o  out  1  memory write request
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_addr_o  out  AddrWidth  memory byte address
- mem_wdata_o  out  DataWidth  memory write data
- mem_strb_o  out  StrbWidth  memory byte enables

Behaviour:
- Reset and clock: clk_i is the clock; rst_ni is the reset, asynchronous, active-low.
- Reset values: all outputs 0; state RESET; registers (id, addr, len, size, burst, beat_cnt, err) all 0.
- State machine: RESET, IDLE, WRITE, SINK, BRESP.
- RESET: all outputs 0; go to IDLE next cycle unconditionally.
- IDLE:
  - aw_ready_o=1; w_ready_o=0; mem_req_o=0.
  - On AW handshake, latch id/addr/len/size/burst; set beat_cnt=0.
  - If size > log2(StrbWidth) or burst==11: set err=1, go to SINK.
  - Otherwise set err=0, go to WRITE.
- WRITE:
  - Combinational pass-through, zero latency: mem_req_o=w_valid_i; w_ready_o=mem_gnt_i; mem_wdata_o=w_data_i; mem_strb_o=w_strb_i; mem_addr_o=addr register.
  - A beat completes when w_valid_i && mem_gnt_i.
  - On beat completion: beat_cnt++ and addr updated.
  - Beat with beat_cnt==len goes to BRESP.
- SINK:
  - w_ready_o=1; mem_req_o=0.
  - Beats are counted identically; beat_cnt==len goes to BRESP.
- Burst termination is count-based only.
- w_last check: w_last_i disagreeing with (beat_cnt==len) on any completed beat sets err=1 (sticky). No extra beats are consumed and none are skipped.
- BRESP:
  - b_valid_o=1; b_id_o=id; b_resp_o = err ? SLVERR : OKAY.
  - b_valid_o holds until b_ready_i, then go to IDLE.
  - b_id_o/b_resp_o stay stable while b_valid_o=1.
- Address update (unit = 1<<size, aligned = addr & ~(unit-1)):
  - FIXED: addr unchanged.
  - INCR: addr = aligned + unit; first beat may be unaligned, later beats aligned.
  - WRAP: see Optional Feature.
  - Arithmetic is modulo 2^AddrWidth; 4 KiB crossing is not checked.
- Throughput and ordering:
  - One burst in flight; AW is never accepted outside IDLE.
  - Minimum per-burst overhead: 1 IDLE cycle + 1 BRESP cycle.
  - W beats arriving before AW are stalled (w_ready_o=0 in IDLE).
- Simultaneous events: a completing final beat and b_ready_i cannot coincide (B is issued next cycle). An AW handshake in the same cycle as the BRESP exit is impossible; aw_ready_o is low in BRESP.
- Reset mid-burst: outputs drop to 0 asynchronously, partial burst is abandoned, no B is issued; RESET then IDLE.

Optional Feature:
- Macro: AXI_TO_MEM_WR_WRAP_EN.
- Defined:
  - WRAP legal only for len in {1,3,7,15}; any other len sets err=1 and the burst goes to SINK.
  - span = (len+1)*unit; base = addr & ~(span-1).
  - Next addr = base | ((aligned + unit) & (span-1)).
- Undefined: burst==10 is illegal like 11 (err=1, SINK, SLVERR).

Test Plan:
- INCR, DataWidth=64: AW addr=0x1000, len=3, size=3, W beats all strb=FF, mem_gnt_i=1 -> mem_addr_o 0x1000, 0x1008, 0x1010, 0x1018; one B with resp=00 and the AW id.
- Unaligned INCR: addr=0x1003, len=1, size=3 -> mem_addr_o 0x1003 then 0x1008.
- FIXED with backpressure: addr=0x40, len=2, mem_gnt_i toggling 0/1 -> three requests all at 0x40; w_ready_o mirrors mem_gnt_i; data order preserved.
- Errors:
  - size=4 with DataWidth=64, len=1 -> two beats sunk, mem_req_o stays 0, b_resp_o=10.
  - w_last_i on beat 0 of len=1 -> both beats written, b_resp_o=10.
- WRAP with macro defined: addr=0x38, len=3, size=3 -> 0x38, 0x20, 0x28, 0x30, OKAY. Without macro -> SLVERR, no mem requests.
- B backpressure and reset: b_ready_i=0 for 5 cycles -> b_valid_o and b_id_o stable, aw_ready_o=0. Assert rst_ni mid-burst -> outputs 0 immediately; first cycle after release aw_ready_o=0, second cycle aw_ready_o=1.
